// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode stage.
// The slave modport is the stage's view; master is the surrounding pipeline.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_fun3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_fun7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_rd_we;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd,
        output out_fun3, out_rs1, out_rs2, out_fun7, out_imm,
        output out_fmt, out_rd_we, out_rs1_used, out_rs2_used,
        output out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd,
        input  out_fun3, out_rs1, out_rs2, out_fun7, out_imm,
        input  out_fmt, out_rd_we, out_rs1_used, out_rs2_used,
        input  out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with one output register,
// valid/ready handshake and flush.
module decode_stage #(
    parameter int XLEN        = 32,
    parameter bit ZERO_UNUSED = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    input logic           flush,
    decode_stage_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    localparam bit RV64 = (XLEN == 64);

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  fun3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  fun7;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign fun3   = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign fun7   = inst[31:25];

    logic is_op, is_op32, is_opimm, is_opimm32, is_load, is_jalr;
    logic is_sys, is_fence, is_store, is_branch, is_upper, is_jal;

    assign is_op      = opcode == 7'b0110011;
    assign is_op32    = RV64 && opcode == 7'b0111011;
    assign is_opimm   = opcode == 7'b0010011;
    assign is_opimm32 = RV64 && opcode == 7'b0011011;
    assign is_load    = opcode == 7'b0000011;
    assign is_jalr    = opcode == 7'b1100111;
    assign is_sys     = opcode == 7'b1110011;
    assign is_fence   = opcode == 7'b0001111;
    assign is_store   = opcode == 7'b0100011;
    assign is_branch  = opcode == 7'b1100011;
    assign is_upper   = opcode == 7'b0110111 || opcode == 7'b0010111;
    assign is_jal     = opcode == 7'b1101111;

    fmt_e            fmt;
    logic            illegal;
    logic            shamt_bad;
    logic [XLEN-1:0] imm;
    logic            en_rd, en_f3, en_rs1, en_rs2, en_f7;
    logic            rd_we, rs1_used, rs2_used;

    // RV64 shifts carry a 6-bit shamt, so only imm[11:6] selects the op
    always_comb begin
        if (RV64)
            shamt_bad = inst[31:26] != 6'b000000 && inst[31:26] != 6'b010000;
        else
            shamt_bad = fun7 != 7'b0000000 && fun7 != 7'b0100000;
    end

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        unique case (1'b1)
            is_op, is_op32: begin
                fmt     = FMT_R;
                illegal = (fun7 != 7'b0000000 && fun7 != 7'b0100000) ||
                          (fun7 == 7'b0100000 && fun3 != 3'b000 && fun3 != 3'b101);
            end
            is_opimm, is_opimm32: begin
                fmt     = FMT_I;
                illegal = (fun3 == 3'b001 || fun3 == 3'b101) && shamt_bad;
            end
            is_load: begin
                fmt     = FMT_I;
                illegal = fun3 == 3'b111 ||
                          (!RV64 && (fun3 == 3'b011 || fun3 == 3'b110));
            end
            is_jalr: begin
                fmt     = FMT_I;
                illegal = fun3 != 3'b000;
            end
            is_sys, is_fence: fmt = FMT_I;
            is_store: begin
                fmt     = FMT_S;
                illegal = fun3[2] || (!RV64 && fun3 == 3'b011);
            end
            is_branch: begin
                fmt     = FMT_B;
                illegal = fun3[2:1] == 2'b01;
            end
            is_upper: fmt = FMT_U;
            is_jal:   fmt = FMT_J;
            default:  illegal = 1'b1;
        endcase
        if (illegal) fmt = FMT_NONE;
    end

    always_comb begin
        imm    = '0;
        en_rd  = 1'b0;
        en_f3  = 1'b0;
        en_rs1 = 1'b0;
        en_rs2 = 1'b0;
        en_f7  = 1'b0;
        unique case (fmt)
            FMT_R: begin
                {en_rd, en_f3, en_rs1, en_rs2, en_f7} = 5'b11111;
            end
            FMT_I: begin
                {en_rd, en_f3, en_rs1} = 3'b111;
                imm       = {XLEN{inst[31]}};
                imm[11:0] = inst[31:20];
            end
            FMT_S: begin
                {en_f3, en_rs1, en_rs2} = 3'b111;
                imm       = {XLEN{inst[31]}};
                imm[11:0] = {inst[31:25], inst[11:7]};
            end
            FMT_B: begin
                {en_f3, en_rs1, en_rs2} = 3'b111;
                imm       = {XLEN{inst[31]}};
                imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            FMT_U: begin
                en_rd     = 1'b1;
                imm       = {XLEN{inst[31]}};
                imm[31:0] = {inst[31:12], 12'b0};
            end
            FMT_J: begin
                en_rd     = 1'b1;
                imm       = {XLEN{inst[31]}};
                imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: imm = '0;
        endcase
    end

    assign rs1_used = en_rs1 && !is_fence && !is_sys;
    assign rs2_used = en_rs2;
    assign rd_we    = en_rd && !is_fence && rd != 5'd0;

    logic            q_valid;
    logic [XLEN-1:0] q_pc;
    logic [6:0]      q_opcode;
    logic [4:0]      q_rd;
    logic [2:0]      q_fun3;
    logic [4:0]      q_rs1;
    logic [4:0]      q_rs2;
    logic [6:0]      q_fun7;
    logic [XLEN-1:0] q_imm;
    logic [2:0]      q_fmt;
    logic            q_rd_we, q_rs1_used, q_rs2_used, q_illegal;
    logic            accept;
    logic            zero_f;

    assign bus.in_ready = !q_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign zero_f       = ZERO_UNUSED || illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid    <= 1'b0;
            q_pc       <= '0;
            q_opcode   <= '0;
            q_rd       <= '0;
            q_fun3     <= '0;
            q_rs1      <= '0;
            q_rs2      <= '0;
            q_fun7     <= '0;
            q_imm      <= '0;
            q_fmt      <= '0;
            q_rd_we    <= 1'b0;
            q_rs1_used <= 1'b0;
            q_rs2_used <= 1'b0;
            q_illegal  <= 1'b0;
        end else begin
            if (flush)            q_valid <= 1'b0;
            else if (accept)      q_valid <= 1'b1;
            else if (bus.out_ready) q_valid <= 1'b0;
            if (accept && !flush) begin
                q_pc       <= bus.in_pc;
                q_opcode   <= opcode;
                q_rd       <= en_rd  ? rd   : (zero_f ? '0 : q_rd);
                q_fun3     <= en_f3  ? fun3 : (zero_f ? '0 : q_fun3);
                q_rs1      <= en_rs1 ? rs1  : (zero_f ? '0 : q_rs1);
                q_rs2      <= en_rs2 ? rs2  : (zero_f ? '0 : q_rs2);
                q_fun7     <= en_f7  ? fun7 : (zero_f ? '0 : q_fun7);
                q_imm      <= imm;
                q_fmt      <= fmt;
                q_rd_we    <= rd_we;
                q_rs1_used <= rs1_used;
                q_rs2_used <= rs2_used;
                q_illegal  <= illegal;
            end
        end
    end

    assign bus.out_valid    = q_valid;
    assign bus.out_pc       = q_pc;
    assign bus.out_opcode   = q_opcode;
    assign bus.out_rd       = q_rd;
    assign bus.out_fun3     = q_fun3;
    assign bus.out_rs1      = q_rs1;
    assign bus.out_rs2      = q_rs2;
    assign bus.out_fun7     = q_fun7;
    assign bus.out_imm      = q_imm;
    assign bus.out_fmt      = q_fmt;
    assign bus.out_rd_we    = q_rd_we;
    assign bus.out_rs1_used = q_rs1_used;
    assign bus.out_rs2_used = q_rs2_used;
    assign bus.out_illegal  = q_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32 and RV64 instances driven in lockstep,
// checked against a transaction-level decode model plus literal vectors.
module tb_decode_stage;
    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  fun3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  fun7;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        rd_we;
        logic        rs1_used;
        logic        rs2_used;
        logic        illegal;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) b32();
    decode_stage_if #(.XLEN(64)) b64();

    assign b32.in_valid  = in_valid;
    assign b32.in_inst   = inst;
    assign b32.in_pc     = pc[31:0];
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_inst   = inst;
    assign b64.in_pc     = pc;
    assign b64.out_ready = out_ready;

    decode_stage #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32)
    );
    decode_stage #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64)
    );

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic [63:0] h;
        h = 64'd1 << (bits - 1);
        return (v ^ h) - h;
    endfunction

    function automatic bundle_t model(input logic [31:0] i,
                                      input logic [63:0] p, input bit rv64);
        bundle_t b;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ill;
        int fm;
        b  = '0;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        ill = 0;
        fm = 0;
        case (op)
            7'h33, 7'h3B: begin
                fm = 1;
                ill = (op == 7'h3B && !rv64) || (f7 != 0 && f7 != 7'h20) ||
                      (f7 == 7'h20 && f3 != 0 && f3 != 5);
            end
            7'h13, 7'h1B: begin
                fm = 2;
                if (op == 7'h1B && !rv64) ill = 1;
                else if (f3 == 1 || f3 == 5)
                    ill = rv64 ? (i[31:26] != 0 && i[31:26] != 6'h10)
                               : (f7 != 0 && f7 != 7'h20);
            end
            7'h03: begin fm = 2; ill = f3 == 7 || (!rv64 && (f3 == 3 || f3 == 6)); end
            7'h67: begin fm = 2; ill = f3 != 0; end
            7'h73, 7'h0F: fm = 2;
            7'h23: begin fm = 3; ill = f3 >= 4 || (!rv64 && f3 == 3); end
            7'h63: begin fm = 4; ill = f3 == 2 || f3 == 3; end
            7'h37, 7'h17: fm = 5;
            7'h6F: fm = 6;
            default: ill = 1;
        endcase
        b.pc = rv64 ? p : (p & 64'hFFFF_FFFF);
        b.opcode = op;
        if (ill) begin
            b.illegal = 1'b1;
            return b;
        end
        b.fmt = 3'(fm);
        if (fm == 1 || fm == 2 || fm == 5 || fm == 6) b.rd = i[11:7];
        if (fm >= 1 && fm <= 4) begin b.fun3 = f3; b.rs1 = i[19:15]; end
        if (fm == 1 || fm == 3 || fm == 4) b.rs2 = i[24:20];
        if (fm == 1) b.fun7 = f7;
        case (fm)
            2: b.imm = sx(64'(i[31:20]), 12);
            3: b.imm = sx(64'({i[31:25], i[11:7]}), 12);
            4: b.imm = sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
            5: b.imm = sx(64'({i[31:12], 12'b0}), 32);
            6: b.imm = sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
            default: b.imm = 64'd0;
        endcase
        b.rs1_used = fm == 1 || fm == 3 || fm == 4 ||
                     (fm == 2 && op != 7'h0F && op != 7'h73);
        b.rs2_used = fm == 1 || fm == 3 || fm == 4;
        b.rd_we = (fm == 1 || fm == 2 || fm == 5 || fm == 6) &&
                  op != 7'h0F && i[11:7] != 0;
        if (!rv64) b.imm = b.imm & 64'hFFFF_FFFF;
        return b;
    endfunction

    bundle_t eb [2];
    bit      ev [2];
    bundle_t act [2];
    logic    act_valid [2];
    logic    act_ready [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                ev[k] <= 1'b0;
                eb[k] <= '0;
            end else if (flush) begin
                ev[k] <= 1'b0;
            end else if (in_valid && (!ev[k] || out_ready)) begin
                ev[k] <= 1'b1;
                eb[k] <= model(inst, pc, k == 1);
            end else if (out_ready) begin
                ev[k] <= 1'b0;
            end
        end
    end

    always_comb begin
        act[0] = '0;
        act[0].pc = 64'(b32.out_pc);
        act[0].opcode = b32.out_opcode;
        act[0].rd = b32.out_rd;
        act[0].fun3 = b32.out_fun3;
        act[0].rs1 = b32.out_rs1;
        act[0].rs2 = b32.out_rs2;
        act[0].fun7 = b32.out_fun7;
        act[0].imm = 64'(b32.out_imm);
        act[0].fmt = b32.out_fmt;
        act[0].rd_we = b32.out_rd_we;
        act[0].rs1_used = b32.out_rs1_used;
        act[0].rs2_used = b32.out_rs2_used;
        act[0].illegal = b32.out_illegal;
        act_valid[0] = b32.out_valid;
        act_ready[0] = b32.in_ready;
        act[1] = '0;
        act[1].pc = b64.out_pc;
        act[1].opcode = b64.out_opcode;
        act[1].rd = b64.out_rd;
        act[1].fun3 = b64.out_fun3;
        act[1].rs1 = b64.out_rs1;
        act[1].rs2 = b64.out_rs2;
        act[1].fun7 = b64.out_fun7;
        act[1].imm = b64.out_imm;
        act[1].fmt = b64.out_fmt;
        act[1].rd_we = b64.out_rd_we;
        act[1].rs1_used = b64.out_rs1_used;
        act[1].rs2_used = b64.out_rs2_used;
        act[1].illegal = b64.out_illegal;
        act_valid[1] = b64.out_valid;
        act_ready[1] = b64.in_ready;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                string t;
                t = (k == 1) ? "x64" : "x32";
                chk({t, ".out_valid"}, 64'(act_valid[k]), 64'(ev[k]));
                chk({t, ".in_ready"}, 64'(act_ready[k]), 64'(!ev[k] || out_ready));
                chk({t, ".pc"}, act[k].pc, eb[k].pc);
                chk({t, ".opcode"}, 64'(act[k].opcode), 64'(eb[k].opcode));
                chk({t, ".rd"}, 64'(act[k].rd), 64'(eb[k].rd));
                chk({t, ".fun3"}, 64'(act[k].fun3), 64'(eb[k].fun3));
                chk({t, ".rs1"}, 64'(act[k].rs1), 64'(eb[k].rs1));
                chk({t, ".rs2"}, 64'(act[k].rs2), 64'(eb[k].rs2));
                chk({t, ".fun7"}, 64'(act[k].fun7), 64'(eb[k].fun7));
                chk({t, ".imm"}, act[k].imm, eb[k].imm);
                chk({t, ".fmt"}, 64'(act[k].fmt), 64'(eb[k].fmt));
                chk({t, ".flags"},
                    64'({act[k].rd_we, act[k].rs1_used, act[k].rs2_used, act[k].illegal}),
                    64'({eb[k].rd_we, eb[k].rs1_used, eb[k].rs2_used, eb[k].illegal}));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] i,
                         input logic [63:0] p, input logic r, input logic f);
        in_valid  = v;
        inst      = i;
        pc        = p;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vecs [24] = '{
        32'h002081B3, 32'h402081B3, 32'h022081B3, 32'h4020D1B3,
        32'h4020C1B3, 32'h4010D093, 32'h02109093, 32'h000080E7,
        32'h000090E7, 32'h00002063, 32'h0000B083, 32'h0000F083,
        32'h0000E083, 32'h0010B023, 32'h0010C023, 32'h008000EF,
        32'h00001297, 32'h0FF0000F, 32'h00000073, 32'h34009073,
        32'h00000013, 32'h0000003B, 32'h800000B7, 32'h00000002
    };

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        inst = '0;
        pc = '0;
        repeat (2) @(negedge clk);
        chk("rst.valid32", 64'(b32.out_valid), 64'd0);
        chk("rst.valid64", 64'(b64.out_valid), 64'd0);
        chk("rst.imm64", b64.out_imm, 64'd0);
        chk("rst.fmt32", 64'(b32.out_fmt), 64'd0);
        chk("rst.ready32", 64'(b32.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1, 32'hFFF00093, 64'h100, 1, 0);
        chk("addi.fmt", 64'(b32.out_fmt), 64'd2);
        chk("addi.rd", 64'(b32.out_rd), 64'd1);
        chk("addi.rs1", 64'(b32.out_rs1), 64'd0);
        chk("addi.imm32", 64'(b32.out_imm), 64'hFFFF_FFFF);
        chk("addi.imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi.flags", 64'({b32.out_rd_we, b32.out_rs1_used,
            b32.out_rs2_used, b32.out_illegal}), 64'b1100);

        drive(1, 32'h0020A423, 64'h104, 1, 0);
        chk("sw.fmt", 64'(b32.out_fmt), 64'd3);
        chk("sw.rs1", 64'(b32.out_rs1), 64'd1);
        chk("sw.rs2", 64'(b32.out_rs2), 64'd2);
        chk("sw.imm", 64'(b32.out_imm), 64'd8);
        chk("sw.rd", 64'(b32.out_rd), 64'd0);
        drive(1, 32'hFE000EE3, 64'h108, 1, 0);
        chk("beq.fmt", 64'(b32.out_fmt), 64'd4);
        chk("beq.imm32", 64'(b32.out_imm), 64'hFFFF_FFFC);
        chk("beq.imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1, 32'h123452B7, 64'h10C, 1, 0);
        chk("lui.fmt", 64'(b32.out_fmt), 64'd5);
        chk("lui.rd", 64'(b32.out_rd), 64'd5);
        chk("lui.imm", 64'(b32.out_imm), 64'h1234_5000);

        for (int j = 0; j < 3; j++) begin
            drive(1, 32'h00500113, 64'h110, 0, 0);
            chk("stall.ready", 64'(b32.in_ready), 64'd0);
            chk("stall.imm", 64'(b32.out_imm), 64'h1234_5000);
            chk("stall.pc", 64'(b32.out_pc), 64'h10C);
        end
        drive(1, 32'h00500113, 64'h110, 1, 0);
        chk("release.imm", 64'(b32.out_imm), 64'd5);
        chk("release.pc", 64'(b32.out_pc), 64'h110);

        drive(1, 32'h00000000, 64'h200, 1, 0);
        chk("ill0.illegal", 64'(b32.out_illegal), 64'd1);
        chk("ill0.fmt", 64'(b32.out_fmt), 64'd0);
        chk("ill0.use", 64'({b32.out_rd_we, b32.out_rs1_used, b32.out_rs2_used}), 64'd0);
        chk("ill0.pc", 64'(b32.out_pc), 64'h200);
        drive(1, 32'h0000007F, 64'h204, 1, 0);
        chk("ill7f.illegal", 64'(b64.out_illegal), 64'd1);
        chk("ill7f.pc", b64.out_pc, 64'h204);

        drive(1, 32'h0010009B, 64'h208, 1, 0);
        chk("addiw64.fmt", 64'(b64.out_fmt), 64'd2);
        chk("addiw64.imm", b64.out_imm, 64'd1);
        chk("addiw64.illegal", 64'(b64.out_illegal), 64'd0);
        chk("addiw32.illegal", 64'(b32.out_illegal), 64'd1);
        drive(0, 32'h0, 64'h0, 1, 0);
        chk("drain.valid", 64'(b32.out_valid), 64'd0);

        for (int j = 0; j < 24; j++)
            drive(1, vecs[j], 64'h1000 + 64'(j * 4), 1, 0);
        for (int j = 0; j < 24; j++)
            drive(j % 3 != 0, vecs[j], 64'hFFFF_0000_0000_2000 + 64'(j * 4),
                  j[0], 0);

        drive(1, 32'h00100093, 64'h300, 1, 0);
        drive(1, 32'h402081B3, 64'h304, 1, 1);
        chk("flush.valid32", 64'(b32.out_valid), 64'd0);
        chk("flush.valid64", 64'(b64.out_valid), 64'd0);
        drive(1, 32'h00200093, 64'h308, 0, 0);
        drive(1, 32'h00300093, 64'h30C, 0, 1);
        chk("flushstall.valid", 64'(b32.out_valid), 64'd0);

        drive(1, 32'h00400093, 64'h310, 1, 0);
        chk("pre_rst.valid", 64'(b32.out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.valid32", 64'(b32.out_valid), 64'd0);
        chk("arst.valid64", 64'(b64.out_valid), 64'd0);
        chk("arst.pc", b64.out_pc, 64'd0);
        in_valid = 1'b0;
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
